tlb_ctrl: RTL and testbench

TLB_CTRL -- requirements
Module: tlb_ctrl

---
 rtl/tlb_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_tlb_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_ctrl.sv
// TLB instruction sequencer: runs TLBP/TLBR/TLBWI against the TLB and CP0.
// Latency: TLBWI/reserved complete at T0+1, TLBP/TLBR at T0+2 after acceptance.
// Backpressure: req_ready is high only in IDLE; one operation in flight at a time.
module tlb_ctrl #(
  parameter int TLBNUM       = 16,
  parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    req_valid,
  input  logic [1:0]              req_op,
  output logic                    req_ready,
  output logic                    done,
  output logic                    refetch,
  input  logic [31:0]             cp0_index,
  input  logic [31:0]             cp0_entryhi,
  input  logic [31:0]             cp0_entrylo0,
  input  logic [31:0]             cp0_entrylo1,
  output logic                    s_valid,
  output logic [18:0]             s_vpn2,
  output logic [7:0]              s_asid,
  input  logic                    s_found,
  input  logic [TLBNUM_WIDTH-1:0] s_index,
  output logic [TLBNUM_WIDTH-1:0] r_index,
  input  logic [18:0]             r_vpn2,
  input  logic [7:0]              r_asid,
  input  logic                    r_g,
  input  logic [24:0]             r_lo0,
  input  logic [24:0]             r_lo1,
  output logic                    w_en,
  output logic [TLBNUM_WIDTH-1:0] w_index,
  output logic [18:0]             w_vpn2,
  output logic [7:0]              w_asid,
  output logic                    w_g,
  output logic [24:0]             w_lo0,
  output logic [24:0]             w_lo1,
  output logic                    cp0_index_wen,
  output logic [31:0]             cp0_index_wdata,
  output logic                    cp0_tlbr_wen,
  output logic [31:0]             cp0_entryhi_wdata,
  output logic [31:0]             cp0_entrylo0_wdata,
  output logic [31:0]             cp0_entrylo1_wdata
);

  localparam logic [1:0] OP_TLBP  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PROBE     = 3'd1,
    PROBE_RSP = 3'd2,
    READ      = 3'd3,
    READ_RSP  = 3'd4,
    WRITE     = 3'd5
  } state_t;

  state_t state, state_n;

  // Next values of the registered strobes.
  logic s_valid_n, w_en_n, cp0_index_wen_n, cp0_tlbr_wen_n, done_n, refetch_n;

  // Operand snapshot taken at acceptance. The opcode itself is captured by
  // the state register (each op owns its own path through the FSM).
  logic [TLBNUM_WIDTH-1:0] snap_index;
  logic [18:0]             snap_vpn2;
  logic [7:0]              snap_asid;
  logic [25:0]             snap_lo0;
  logic [25:0]             snap_lo1;

  logic accept;

  // CP0 bits that never reach the TLB (Index P bit and upper index bits,
  // EntryHi[12:8], EntryLo[31:26]).
  logic unused_bits;
  assign unused_bits = ^{cp0_index[31:TLBNUM_WIDTH], cp0_entryhi[12:8],
                         cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // State register and registered strobes; reset squashes any pending strobe.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      s_valid       <= 1'b0;
      w_en          <= 1'b0;
      cp0_index_wen <= 1'b0;
      cp0_tlbr_wen  <= 1'b0;
      done          <= 1'b0;
      refetch       <= 1'b0;
    end else begin
      state         <= state_n;
      s_valid       <= s_valid_n;
      w_en          <= w_en_n;
      cp0_index_wen <= cp0_index_wen_n;
      cp0_tlbr_wen  <= cp0_tlbr_wen_n;
      done          <= done_n;
      refetch       <= refetch_n;
    end
  end

  // Capture the CP0 operands once so later CP0 updates cannot disturb the op.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      snap_index <= '0;
      snap_vpn2  <= '0;
      snap_asid  <= '0;
      snap_lo0   <= '0;
      snap_lo1   <= '0;
    end else if (accept) begin
      snap_index <= cp0_index[TLBNUM_WIDTH-1:0];
      snap_vpn2  <= cp0_entryhi[31:13];
      snap_asid  <= cp0_entryhi[7:0];
      snap_lo0   <= cp0_entrylo0[25:0];
      snap_lo1   <= cp0_entrylo1[25:0];
    end
  end

  // Next-state and next-strobe decode; strobes are raised one cycle early so
  // they leave the block straight from flops.
  always_comb begin
    state_n         = state;
    s_valid_n       = 1'b0;
    w_en_n          = 1'b0;
    cp0_index_wen_n = 1'b0;
    cp0_tlbr_wen_n  = 1'b0;
    done_n          = 1'b0;
    refetch_n       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_TLBP: begin
              state_n   = PROBE;
              s_valid_n = 1'b1;
            end
            OP_TLBR: begin
              state_n = READ;
            end
            OP_TLBWI: begin
              state_n   = WRITE;
              w_en_n    = 1'b1;
              done_n    = 1'b1;
              refetch_n = 1'b1;
            end
            default: begin
              // Reserved op: complete as a no-op.
              state_n = WRITE;
              done_n  = 1'b1;
            end
          endcase
        end
      end
      PROBE: begin
        state_n         = PROBE_RSP;
        cp0_index_wen_n = 1'b1;
        done_n          = 1'b1;
      end
      READ: begin
        state_n        = READ_RSP;
        cp0_tlbr_wen_n = 1'b1;
        done_n         = 1'b1;
        refetch_n      = 1'b1;
      end
      PROBE_RSP, READ_RSP, WRITE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // TLB request data comes straight from the snapshot (zero after reset).
  assign s_vpn2  = snap_vpn2;
  assign s_asid  = snap_asid;
  assign r_index = snap_index;
  assign w_index = snap_index;
  assign w_vpn2  = snap_vpn2;
  assign w_asid  = snap_asid;
  assign w_g     = snap_lo0[0] & snap_lo1[0];
  assign w_lo0   = snap_lo0[25:1];
  assign w_lo1   = snap_lo1[25:1];

  // CP0 write data is formed from the TLB response and held at zero outside
  // its strobe, so stale TLB outputs never leak onto the CP0 bus.
  assign cp0_index_wdata = cp0_index_wen ?
      {~s_found, {(31-TLBNUM_WIDTH){1'b0}}, (s_found ? s_index : {TLBNUM_WIDTH{1'b0}})} :
      32'd0;
  assign cp0_entryhi_wdata  = cp0_tlbr_wen ? {r_vpn2, 5'b0, r_asid} : 32'd0;
  assign cp0_entrylo0_wdata = cp0_tlbr_wen ? {6'b0, r_lo0, r_g}    : 32'd0;
  assign cp0_entrylo1_wdata = cp0_tlbr_wen ? {6'b0, r_lo1, r_g}    : 32'd0;

endmodule

// File: tb/tb_tlb_ctrl.sv
// Self-checking bench for tlb_ctrl: a small behavioural TLB answers searches,
// reads and writes, and a reference TLB table predicts every result.
module tb_tlb_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [1:0]  req_op;
  logic        req_ready, done, refetch;
  logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
  logic        s_valid;
  logic [18:0] s_vpn2;
  logic [7:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index;
  logic [3:0]  r_index;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [24:0] r_lo0, r_lo1;
  logic        w_en;
  logic [3:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic        w_g;
  logic [24:0] w_lo0, w_lo1;
  logic        cp0_index_wen, cp0_tlbr_wen;
  logic [31:0] cp0_index_wdata, cp0_entryhi_wdata, cp0_entrylo0_wdata, cp0_entrylo1_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tlb_ctrl #(.TLBNUM(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .done(done), .refetch(refetch),
    .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .s_valid(s_valid), .s_vpn2(s_vpn2), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_lo0(r_lo0), .r_lo1(r_lo1),
    .w_en(w_en), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid),
    .w_g(w_g), .w_lo0(w_lo0), .w_lo1(w_lo1),
    .cp0_index_wen(cp0_index_wen), .cp0_index_wdata(cp0_index_wdata),
    .cp0_tlbr_wen(cp0_tlbr_wen),
    .cp0_entryhi_wdata(cp0_entryhi_wdata),
    .cp0_entrylo0_wdata(cp0_entrylo0_wdata),
    .cp0_entrylo1_wdata(cp0_entrylo1_wdata)
  );

  // {req_ready, s_valid, w_en, cp0_index_wen, cp0_tlbr_wen, done, refetch}
  logic [6:0] strobes;
  assign strobes = {req_ready, s_valid, w_en, cp0_index_wen, cp0_tlbr_wen, done, refetch};

  // Behavioural TLB: one-cycle search and read latency, write on w_en.
  logic        env_valid [16];
  logic [18:0] env_vpn2  [16];
  logic [7:0]  env_asid  [16];
  logic        env_g     [16];
  logic [24:0] env_lo0   [16];
  logic [24:0] env_lo1   [16];

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) begin
        env_valid[i] <= 1'b0;
        env_vpn2[i]  <= '0;
        env_asid[i]  <= '0;
        env_g[i]     <= 1'b0;
        env_lo0[i]   <= '0;
        env_lo1[i]   <= '0;
      end
      s_found <= 1'b0;
      s_index <= '0;
      r_vpn2  <= '0;
      r_asid  <= '0;
      r_g     <= 1'b0;
      r_lo0   <= '0;
      r_lo1   <= '0;
    end else begin
      if (w_en) begin
        env_valid[w_index] <= 1'b1;
        env_vpn2[w_index]  <= w_vpn2;
        env_asid[w_index]  <= w_asid;
        env_g[w_index]     <= w_g;
        env_lo0[w_index]   <= w_lo0;
        env_lo1[w_index]   <= w_lo1;
      end
      if (s_valid) begin
        s_found <= 1'b0;
        s_index <= '0;
        for (int i = 15; i >= 0; i--) begin
          if (env_valid[i] && env_vpn2[i] == s_vpn2 && (env_g[i] || env_asid[i] == s_asid)) begin
            s_found <= 1'b1;
            s_index <= 4'(i);
          end
        end
      end
      r_vpn2 <= env_vpn2[r_index];
      r_asid <= env_asid[r_index];
      r_g    <= env_g[r_index];
      r_lo0  <= env_lo0[r_index];
      r_lo1  <= env_lo1[r_index];
    end
  end

  // Reference TLB contents as the architecture says they should be.
  logic        ref_valid [16];
  logic [18:0] ref_vpn2  [16];
  logic [7:0]  ref_asid  [16];
  logic        ref_g     [16];
  logic [24:0] ref_lo0   [16];
  logic [24:0] ref_lo1   [16];

  // Values seen at the completion cycle of the most recent op.
  logic [31:0] obs_index_wdata, obs_lo0_wdata, obs_lo1_wdata;
  logic [3:0]  obs_w_index;
  logic        obs_w_g;

  task automatic clear_ref();
    for (int i = 0; i < 16; i++) begin
      ref_valid[i] = 1'b0;
      ref_vpn2[i]  = '0;
      ref_asid[i]  = '0;
      ref_g[i]     = 1'b0;
      ref_lo0[i]   = '0;
      ref_lo1[i]   = '0;
    end
  endtask

  // Issue one op and check every cycle from acceptance to the return to IDLE.
  task automatic do_op(input logic [1:0] op, input logic [31:0] idx_reg,
                       input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    logic [3:0]  idx;
    int          lat;
    int          hit;
    logic [31:0] exp_iw;
    logic [6:0]  exp_st;
    idx = idx_reg[3:0];
    hit = -1;
    for (int i = 0; i < 16; i++)
      if (hit < 0 && ref_valid[i] && ref_vpn2[i] == hi[31:13] && (ref_g[i] || ref_asid[i] == hi[7:0]))
        hit = i;
    exp_iw = (hit < 0) ? 32'h8000_0000 : 32'(hit);
    lat = (op == 2'b00 || op == 2'b01) ? 2 : 1;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    cp0_index = idx_reg;
    cp0_entryhi = hi;
    cp0_entrylo0 = lo0;
    cp0_entrylo1 = lo1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2) req_valid = 1'b0;
      exp_st = '0;
      exp_st[6] = (k == 0) || (k > lat);
      if (k == lat) begin
        exp_st[1] = 1'b1;
        if (op == 2'b00) exp_st[3] = 1'b1;
        if (op == 2'b01) begin exp_st[2] = 1'b1; exp_st[0] = 1'b1; end
        if (op == 2'b10) begin exp_st[4] = 1'b1; exp_st[0] = 1'b1; end
      end
      if (op == 2'b00 && k == 1) exp_st[5] = 1'b1;
      total++;
      if (strobes !== exp_st) begin
        bad++;
        $display("FAIL strobes op=%0d cycle=T0+%0d got=%b want=%b", op, k, strobes, exp_st);
      end
      if (op == 2'b00 && k == 1) begin
        total++;
        if ({s_vpn2, s_asid} !== {hi[31:13], hi[7:0]}) begin
          bad++;
          $display("FAIL search_key got=%h/%h want=%h/%h", s_vpn2, s_asid, hi[31:13], hi[7:0]);
        end
      end
      if (op == 2'b00 && k == 2) begin
        obs_index_wdata = cp0_index_wdata;
        total++;
        if (cp0_index_wdata !== exp_iw) begin
          bad++;
          $display("FAIL probe_index got=%h want=%h", cp0_index_wdata, exp_iw);
        end
      end
      if (op == 2'b01 && k == 1) begin
        total++;
        if (r_index !== idx) begin
          bad++;
          $display("FAIL read_index got=%0d want=%0d", r_index, idx);
        end
      end
      if (op == 2'b01 && k == 2) begin
        obs_lo0_wdata = cp0_entrylo0_wdata;
        obs_lo1_wdata = cp0_entrylo1_wdata;
        total++;
        if ({cp0_entryhi_wdata, cp0_entrylo0_wdata, cp0_entrylo1_wdata} !==
            {ref_vpn2[idx], 5'b0, ref_asid[idx], 6'b0, ref_lo0[idx], ref_g[idx],
             6'b0, ref_lo1[idx], ref_g[idx]}) begin
          bad++;
          $display("FAIL read_data idx=%0d got=%h %h %h want=%h %h %h", idx,
                   cp0_entryhi_wdata, cp0_entrylo0_wdata, cp0_entrylo1_wdata,
                   {ref_vpn2[idx], 5'b0, ref_asid[idx]}, {6'b0, ref_lo0[idx], ref_g[idx]},
                   {6'b0, ref_lo1[idx], ref_g[idx]});
        end
      end
      if (op == 2'b10 && k == 1) begin
        obs_w_index = w_index;
        obs_w_g = w_g;
        total++;
        if ({w_index, w_vpn2, w_asid, w_g, w_lo0, w_lo1} !==
            {idx, hi[31:13], hi[7:0], lo0[0] & lo1[0], lo0[25:1], lo1[25:1]}) begin
          bad++;
          $display("FAIL write_data got=%0d %h %h %b %h %h want=%0d %h %h %b %h %h",
                   w_index, w_vpn2, w_asid, w_g, w_lo0, w_lo1,
                   idx, hi[31:13], hi[7:0], lo0[0] & lo1[0], lo0[25:1], lo1[25:1]);
        end
      end
      if (k == 1) begin
        // Disturb every input once the op is in flight; none of it may matter.
        req_valid = 1'($urandom_range(0, 1));
        req_op = 2'($urandom_range(0, 3));
        cp0_index = $urandom;
        cp0_entryhi = $urandom;
        cp0_entrylo0 = $urandom;
        cp0_entrylo1 = $urandom;
      end
    end
    if (op == 2'b10) begin
      ref_valid[idx] = 1'b1;
      ref_vpn2[idx]  = hi[31:13];
      ref_asid[idx]  = hi[7:0];
      ref_g[idx]     = lo0[0] & lo1[0];
      ref_lo0[idx]   = lo0[25:1];
      ref_lo1[idx]   = lo1[25:1];
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req_valid = 1'b1;
    req_op = 2'b10;
    cp0_index = $urandom;
    cp0_entryhi = $urandom;
    cp0_entrylo0 = $urandom | 32'h1;
    cp0_entrylo1 = $urandom | 32'h1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (strobes !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=1000000", strobes);
    end
    req_valid = 1'b0;
    resetn = 1'b1;
    clear_ref();
    @(negedge clk);
    total++;
    if (strobes !== 7'b1000000) begin
      bad++;
      $display("FAIL post_reset_strobes got=%b want=1000000", strobes);
    end
    total++;
    if ({s_vpn2, s_asid, r_index, w_index, w_vpn2, w_asid, w_g, w_lo0, w_lo1,
         cp0_index_wdata, cp0_entryhi_wdata, cp0_entrylo0_wdata, cp0_entrylo1_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_data got=%h %h %h %h %h want=0", s_vpn2, s_asid, w_lo0, w_lo1, cp0_index_wdata);
    end
  endtask

  task automatic test_directed();
    do_op(2'b10, 32'd5, 32'h0040_2005, 32'h0000_0ABC, 32'h0000_0DE4);
    do_op(2'b00, 32'd0, 32'h0040_2005, 32'd0, 32'd0);
    total++;
    if (obs_index_wdata !== 32'h0000_0005) begin
      bad++;
      $display("FAIL probe_hit got=%h want=00000005", obs_index_wdata);
    end
    do_op(2'b00, 32'd0, 32'h1234_6077, 32'd0, 32'd0);
    total++;
    if (obs_index_wdata !== 32'h8000_0000) begin
      bad++;
      $display("FAIL probe_miss got=%h want=80000000", obs_index_wdata);
    end
    do_op(2'b10, 32'h8000_0003, 32'h0000_6011, 32'h0000_1007, 32'h0000_2006);
    total++;
    if ({obs_w_index, obs_w_g} !== {4'd3, 1'b0}) begin
      bad++;
      $display("FAIL tlbwi_pbit got=%0d/%b want=3/0", obs_w_index, obs_w_g);
    end
    do_op(2'b01, 32'd3, 32'd0, 32'd0, 32'd0);
    total++;
    if ({obs_lo0_wdata, obs_lo1_wdata} !== {32'h0000_1006, 32'h0000_2006}) begin
      bad++;
      $display("FAIL tlbr_lo got=%h/%h want=00001006/00002006", obs_lo0_wdata, obs_lo1_wdata);
    end
    do_op(2'b11, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
  endtask

  task automatic test_random();
    logic [31:0] hi;
    repeat (40) begin
      hi = {19'(32'h100 + $urandom_range(0, 3)), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 3))};
      do_op(2'($urandom_range(0, 3)), $urandom, hi, $urandom, $urandom);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  done_seq, ready_seq, iwen_seq;
    logic [31:0] hi;
    logic [31:0] iw_at4;
    hi = {19'h7ABCD, 5'd0, 8'h33};
    iw_at4 = '0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'b10;
    cp0_index = 32'd7;
    cp0_entryhi = hi;
    cp0_entrylo0 = 32'h0000_0456;
    cp0_entrylo1 = 32'h0000_0788;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) begin
        req_op = 2'b00;
        cp0_index = 32'd0;
      end
      if (k == 3) req_valid = 1'b0;
      done_seq[k]  = done;
      ready_seq[k] = req_ready;
      iwen_seq[k]  = cp0_index_wen;
      if (k == 4) iw_at4 = cp0_index_wdata;
    end
    ref_valid[7] = 1'b1;
    ref_vpn2[7]  = hi[31:13];
    ref_asid[7]  = hi[7:0];
    ref_g[7]     = 1'b0;
    ref_lo0[7]   = 25'h22B;
    ref_lo1[7]   = 25'h3C4;
    total++;
    if (done_seq !== 6'b010010) begin
      bad++;
      $display("FAIL b2b_done got=%b want=010010", done_seq);
    end
    total++;
    if (ready_seq !== 6'b100101) begin
      bad++;
      $display("FAIL b2b_ready got=%b want=100101", ready_seq);
    end
    total++;
    if ({iwen_seq, iw_at4} !== {6'b010000, 32'd7}) begin
      bad++;
      $display("FAIL b2b_probe got=%b/%h want=010000/00000007", iwen_seq, iw_at4);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] seen;
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'b01;
    cp0_index = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    total++;
    if (strobes !== 7'b1000000) begin
      bad++;
      $display("FAIL mid_reset_strobes got=%b want=1000000", strobes);
    end
    resetn = 1'b1;
    clear_ref();
    seen = '0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | {cp0_tlbr_wen, done};
    end
    total++;
    if ({seen, req_ready} !== 3'b001) begin
      bad++;
      $display("FAIL mid_reset_pulses got=%b want=001", {seen, req_ready});
    end
    do_op(2'b01, 32'd5, 32'd0, 32'd0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
